// File: rtl/uart_tx.sv
// AXI4-Stream to 8N1 UART transmitter with a one-entry holding register.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t                r_state;
  logic [18:0]           r_cnt;
  logic [18:0]           r_period;
  logic [3:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_valid;
  logic                  r_tready;
  logic                  r_txd;
  logic                  r_busy;
`ifdef UART_TX_PARITY_EN
  logic                  r_par;
`endif

  logic [15:0] w_ps;
  logic [18:0] w_period;
  logic        w_tick;
  logic        w_stop_done;
  logic        w_load;
  logic        w_accept;
  logic        w_hold_next;
  logic        w_idle_next;

  // prescale of 0 behaves as 1
  assign w_ps        = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_period    = {w_ps, 3'b000};
  assign w_tick      = (r_cnt == 19'd0);
  assign w_stop_done = (r_state == S_STOP) && w_tick &&
                       (r_idx == 4'(STOP_BITS - 1));
  assign w_load      = r_hold_valid &&
                       ((r_state == S_IDLE) || w_stop_done);
  assign w_accept    = s_axis_tvalid && r_tready;
  assign w_hold_next = w_accept || (r_hold_valid && !w_load);
  assign w_idle_next = ((r_state == S_IDLE) || w_stop_done) &&
                       !r_hold_valid;

  assign s_axis_tready = r_tready;
  assign txd           = r_txd;
  assign busy          = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_period     <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_tready     <= 1'b1;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_hold_valid <= w_hold_next;
      r_tready     <= !w_hold_next;
      r_busy       <= !w_idle_next || w_hold_next;
      if (w_accept)
        r_hold <= s_axis_tdata;
      if (w_load) begin
        // start bit goes out on the same edge as the load
        r_shift  <= r_hold;
        r_period <= w_period;
        r_cnt    <= w_period - 19'd1;
        r_txd    <= 1'b0;
        r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
        r_par    <= ^r_hold;
`endif
      end else if (r_state != S_IDLE) begin
        if (!w_tick) begin
          r_cnt <= r_cnt - 19'd1;
        end else begin
          r_cnt <= r_period - 19'd1;
          unique case (r_state)
            S_START: begin
              r_txd   <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= '0;
              r_state <= S_DATA;
            end
            S_DATA: begin
              if (r_idx == 4'(DATA_WIDTH - 1)) begin
                r_idx <= '0;
`ifdef UART_TX_PARITY_EN
                r_txd   <= r_par;
                r_state <= S_PARITY;
`else
                r_txd   <= 1'b1;
                r_state <= S_STOP;
`endif
              end else begin
                r_txd   <= r_shift[0];
                r_shift <= r_shift >> 1;
                r_idx   <= r_idx + 4'd1;
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
              r_txd   <= 1'b1;
              r_idx   <= '0;
              r_state <= S_STOP;
            end
`endif
            S_STOP: begin
              r_txd <= 1'b1;
              if (w_stop_done)
                r_state <= S_IDLE;
              else
                r_idx <= r_idx + 4'd1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: every frame is checked cycle by cycle.
// Build with UART_TX_PARITY_EN to exercise the parity variant.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 1 + 8 + PAR + 1;

  typedef struct {
    logic [7:0] d;
    int         p;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        txd;
  logic        busy;
  logic [15:0] prescale = 16'd1;

  sb_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  last_acc = 0;
  int  cur_p = 1;

  uart_tx #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .txd(txd),
    .busy(busy),
    .prescale(prescale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic set_p(input int p);
    prescale = 16'(p);
    cur_p = p;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_timeout: tready=%b want 1", s_axis_tready);
      s_axis_tvalid = 1'b0;
      return;
    end
    exp_q.push_back('{d: d, p: cur_p});
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic check_frame(input int max_wait, input bit chk_lat,
                             input string tag);
    int w = 0;
    int pp;
    sb_t e;
    logic [NB-1:0] bits;
    int good[NB];
    logic [7:0] got;
    while (w < max_wait) begin
      @(negedge clk);
      w++;
      if (txd === 1'b0) break;
    end
    n_cmp++;
    if (txd !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start: txd=%b want 0 within %0d", tag, txd, max_wait);
      return;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s sb_empty: got frame want none", tag);
      return;
    end
    e = exp_q.pop_front();
    if (chk_lat) begin
      n_cmp++;
      if (cyc - last_acc !== 1) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want 1", tag, cyc - last_acc);
      end
    end
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s tready_at_load: got %b want 1", tag, s_axis_tready);
    end
    pp = ((e.p == 0) ? 1 : e.p) * 8;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = e.d[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^e.d;
`endif
    foreach (good[b]) good[b] = 0;
    got = '0;
    for (int c = 0; c < NB * pp; c++) begin
      if (c > 0) @(negedge clk);
      if (txd === bits[c/pp]) good[c/pp]++;
      if (c % pp == pp / 2 && c / pp >= 1 && c / pp <= 8)
        got[c/pp-1] = txd;
    end
    for (int b = 0; b < NB; b++) begin
      n_cmp++;
      if (good[b] !== pp) begin
        n_bad++;
        $display("FAIL %s bit%0d: %0d good cycles want %0d (bit=%b)",
                 tag, b, good[b], pp, bits[b]);
      end
    end
    n_cmp++;
    if (got !== e.d) begin
      n_bad++;
      $display("FAIL %s data: got %h want %h", tag, got, e.d);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    n_cmp++;
    if ({txd, busy, s_axis_tready} !== 3'b101) begin
      n_bad++;
      $display("FAIL %s idle: txd/busy/tready=%b%b%b want 101",
               tag, txd, busy, s_axis_tready);
    end
  endtask

  task automatic test_reset();
    int hi = 0;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    set_p(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({txd, busy, s_axis_tready} !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_vals: txd/busy/tready=%b%b%b want 101",
               txd, busy, s_axis_tready);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (txd === 1'b1) hi++;
    end
    n_cmp++;
    if (hi !== 100) begin
      n_bad++;
      $display("FAIL reset_hold: txd high %0d cycles want 100", hi);
    end
  endtask

  task automatic test_single();
    set_p(1);
    send(8'h55);
    s_axis_tvalid = 1'b0;
    n_cmp++;
    if ({busy, s_axis_tready} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_accept: busy/tready=%b%b want 10",
               busy, s_axis_tready);
    end
    check_frame(50, 1, "single55");
    check_idle("single55");
  endtask

  task automatic test_back_to_back();
    set_p(2);
    fork
      begin
        send(8'hA3);
        send(8'h0F);
        n_cmp++;
        if (s_axis_tready !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_tready: got %b want 0", s_axis_tready);
        end
        s_axis_tvalid = 1'b0;
      end
      begin
        check_frame(50, 1, "b2b_A3");
        check_frame(1, 0, "b2b_0F");
      end
    join
    check_idle("b2b");
  endtask

  task automatic test_prescale_zero();
    set_p(0);
    send(8'h5A);
    s_axis_tvalid = 1'b0;
    check_frame(50, 1, "p0");
    check_idle("p0");
    set_p(1);
    send(8'h5A);
    s_axis_tvalid = 1'b0;
    check_frame(50, 1, "p1");
    check_idle("p1");
  endtask

  task automatic test_reset_mid();
    int hi = 0;
    set_p(1);
    send(8'hC6);
    send(8'h99);
    s_axis_tvalid = 1'b0;
    repeat (34) @(negedge clk);
    n_cmp++;
    if (txd !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_bit3: txd=%b want 0", txd);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_cmp++;
    if ({txd, busy, s_axis_tready} !== 3'b101) begin
      n_bad++;
      $display("FAIL mid_reset: txd/busy/tready=%b%b%b want 101",
               txd, busy, s_axis_tready);
    end
    repeat (30) begin
      @(negedge clk);
      if (txd === 1'b1) hi++;
    end
    n_cmp++;
    if (hi !== 30) begin
      n_bad++;
      $display("FAIL mid_drop: txd high %0d cycles want 30", hi);
    end
    send(8'h3C);
    s_axis_tvalid = 1'b0;
    check_frame(50, 1, "after_rst");
    check_idle("after_rst");
  endtask

  task automatic test_random();
    set_p(int'($urandom_range(1, 3)));
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(8'($urandom_range(0, 255)));
          if ($urandom_range(0, 1) == 1) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        s_axis_tvalid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) check_frame(4000, 0, "rand");
      end
    join
    check_idle("rand");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    set_p(1);
    send(8'h55);
    s_axis_tvalid = 1'b0;
    check_frame(50, 1, "par55");
    check_idle("par55");
    send(8'h07);
    s_axis_tvalid = 1'b0;
    check_frame(50, 1, "par07");
    check_idle("par07");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_prescale_zero();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
